// File: rtl/i2c_write_engine.sv
// Single-master I2C write serializer: START, three bytes with ACK slots, STOP, timed by a quarter-bit tick.
// Build option: define I2C_NACK_ABORT_EN to jump to STOP after the first NACK instead of sending every byte.
module i2c_write_engine #(
   parameter int CLK_FREQ = 50000000,
   parameter int I2C_FREQ = 20000,
   parameter int TICK_DIV = CLK_FREQ / (4 * I2C_FREQ)
) (
   input  logic        CLOCK_50,
   input  logic        iRST_N,
   input  logic [23:0] iDATA,
   input  logic        iGO,
   output logic        oEND,
   output logic        oACK,
   output logic        oBUSY,
   output logic        I2C_SCLK,
   inout  wire         I2C_SDAT
);

   localparam int                DIV_W    = $clog2(TICK_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] SEND  = 3'd2;
   localparam logic [2:0] ACK   = 3'd3;
   localparam logic [2:0] STOP  = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

`ifdef I2C_NACK_ABORT_EN
   localparam logic NACK_ABORT = 1'b1;
`else
   localparam logic NACK_ABORT = 1'b0;
`endif

   logic [DIV_W-1:0] divCnt;
   logic             tick;
   logic [2:0]       state;
   logic [1:0]       quarter;
   logic [2:0]       bitCnt;
   logic [1:0]       byteCnt;
   logic [23:0]      shiftReg;
   logic             nackFlag;
   logic             sclReg;
   logic             sdaLow;

   assign tick     = (divCnt == DIV_LAST);
   assign I2C_SCLK = sclReg;
   // Open-drain: only ever pull low, the bus pull-up supplies the high level.
   assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;

   always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         divCnt   <= '0;
         state    <= IDLE;
         quarter  <= 2'd0;
         bitCnt   <= 3'd0;
         byteCnt  <= 2'd0;
         shiftReg <= 24'd0;
         nackFlag <= 1'b0;
         oEND     <= 1'b0;
         oACK     <= 1'b0;
         oBUSY    <= 1'b0;
         sclReg   <= 1'b1;
         sdaLow   <= 1'b0;
      end else begin
         divCnt <= tick ? '0 : divCnt + 1'b1;
         case (state)
            IDLE: begin
               if (iGO) begin
                  shiftReg <= iDATA;
                  nackFlag <= 1'b0;
                  oBUSY    <= 1'b1;
                  quarter  <= 2'd0;
                  bitCnt   <= 3'd0;
                  byteCnt  <= 2'd0;
                  state    <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (quarter == 2'd0) begin
                     quarter <= 2'd1;
                     sdaLow  <= 1'b1;
                  end else begin
                     quarter <= 2'd0;
                     sclReg  <= 1'b0;
                     sdaLow  <= ~shiftReg[23];
                     state   <= SEND;
                  end
               end
            end
            SEND: begin
               if (tick) begin
                  quarter <= quarter + 2'd1;
                  case (quarter)
                     2'd0: sclReg <= 1'b1;
                     2'd2: begin
                        // Shift while SCL is low so the next bit is ready for the following q0.
                        sclReg   <= 1'b0;
                        shiftReg <= {shiftReg[22:0], 1'b0};
                     end
                     2'd3: begin
                        if (bitCnt == 3'd7) begin
                           bitCnt <= 3'd0;
                           sdaLow <= 1'b0;
                           state  <= ACK;
                        end else begin
                           bitCnt <= bitCnt + 3'd1;
                           sdaLow <= ~shiftReg[23];
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ACK: begin
               if (tick) begin
                  quarter <= quarter + 2'd1;
                  case (quarter)
                     2'd0: sclReg <= 1'b1;
                     2'd2: begin
                        sclReg   <= 1'b0;
                        nackFlag <= nackFlag | I2C_SDAT;
                     end
                     2'd3: begin
                        if (byteCnt < 2'd2 && !(NACK_ABORT && nackFlag)) begin
                           byteCnt <= byteCnt + 2'd1;
                           sdaLow  <= ~shiftReg[23];
                           state   <= SEND;
                        end else begin
                           sdaLow  <= 1'b1;
                           state   <= STOP;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            STOP: begin
               if (tick) begin
                  case (quarter)
                     2'd0: begin
                        sclReg  <= 1'b1;
                        quarter <= 2'd1;
                     end
                     2'd1: begin
                        sdaLow  <= 1'b0;
                        quarter <= 2'd2;
                     end
                     default: begin
                        quarter <= 2'd0;
                        oEND    <= 1'b1;
                        oACK    <= nackFlag;
                        state   <= DONE;
                     end
                  endcase
               end
            end
            DONE: begin
               // Level handshake: hold completion until the sequencer drops its request.
               if (!iGO) begin
                  oEND  <= 1'b0;
                  oBUSY <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: bus monitor plus ACK/NACK slave, checked against a per-word frame model.
// Honours I2C_NACK_ABORT_EN the same way as the design build.
module tb_i2c_write_engine;
   localparam int CLK_FREQ = 400;
   localparam int I2C_FREQ = 25;
   localparam int TICK_DIV = CLK_FREQ / (4 * I2C_FREQ);

`ifdef I2C_NACK_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstN;
   logic [23:0] data;
   logic        go;
   logic        endFlag, ackFlag, busy, scl;
   wire         sdaLine;
   logic        slavePull = 1'b0;

   int          assertCnt = 0;
   int          failCnt = 0;
   int          startCnt = 0;
   int          stopCnt = 0;
   int          riseCnt = 0;
   bit          obsBits[$];
   logic [2:0]  nackMask = 3'b000;
   logic        sclPrev = 1'b1;
   logic        sdaPrev = 1'b1;

   assign sdaLine = slavePull ? 1'b0 : 1'bz;
   pullup (sdaLine);

   i2c_write_engine #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .TICK_DIV(TICK_DIV)) dut (
      .CLOCK_50(clk),
      .iRST_N  (rstN),
      .iDATA   (data),
      .iGO     (go),
      .oEND    (endFlag),
      .oACK    (ackFlag),
      .oBUSY   (busy),
      .I2C_SCLK(scl),
      .I2C_SDAT(sdaLine)
   );

   always #5 clk = ~clk;

   // Bus monitor and slave, sampled on the inactive clock edge where SCL/SDA are settled.
   always @(negedge clk) begin
      logic sclNow, sdaNow;
      int   byteIdx;
      sclNow = scl;
      sdaNow = sdaLine;
      if (sclPrev && sclNow && sdaPrev && !sdaNow) begin
         startCnt++;
         obsBits.delete();
         riseCnt   = 0;
         slavePull = 1'b0;
      end else if (sclPrev && sclNow && !sdaPrev && sdaNow) begin
         stopCnt++;
         if (obsBits.size() > 0) void'(obsBits.pop_back());
      end else if (!sclPrev && sclNow) begin
         obsBits.push_back(sdaNow);
         riseCnt++;
      end else if (sclPrev && !sclNow) begin
         byteIdx = riseCnt / 9;
         if (riseCnt % 9 == 8 && byteIdx < 3 && !nackMask[byteIdx]) slavePull = 1'b1;
         else slavePull = 1'b0;
      end
      sclPrev = sclNow;
      sdaPrev = sdaNow;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Frame model: data bits MSB first with the slave's ACK bit after each byte.
   task automatic model(input logic [23:0] word, input logic [2:0] nack,
                        output logic [26:0] expVec, output int expLen,
                        output logic expAck, output int expTicks);
      int         nBytes;
      logic [7:0] byteVal;
      nBytes = 3;
      expVec = '0;
      expLen = 0;
      expAck = 1'b0;
      for (int b = 0; b < 3; b++) begin
         byteVal = word[23 - 8*b -: 8];
         for (int i = 7; i >= 0; i--) begin
            expVec = {expVec[25:0], byteVal[i]};
            expLen++;
         end
         expVec = {expVec[25:0], nack[b]};
         expLen++;
         expAck = expAck | nack[b];
         if (ABORT && nack[b] && b < 2) begin
            nBytes = b + 1;
            break;
         end
      end
      expTicks = 2 + 36 * nBytes + 3;
   endtask

   task automatic runTxn(input string tag, input logic [23:0] word, input logic [2:0] nack,
                         input int holdCycles, input bit disturb);
      logic [26:0] expVec, obsVec;
      logic        expAck;
      int          expLen, expTicks, cyc, startBase, stopBase, holdDrop;
      model(word, nack, expVec, expLen, expAck, expTicks);
      @(negedge clk);
      nackMask  = nack;
      data      = word;
      go        = 1'b1;
      startBase = startCnt;
      stopBase  = stopCnt;
      @(posedge clk);
      #1;
      check({tag, ":busy_on_accept"}, busy, 1'b1);
      cyc = 0;
      while (!endFlag && cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (disturb && cyc >= 20 && cyc < 400 && cyc % 37 == 0) begin
            go   = ~go;
            data = 24'($urandom);
         end
         if (disturb && cyc == 400) go = 1'b1;
      end
      check({tag, ":end_seen"}, endFlag, 1'b1);
      assertCnt++;
      assert (cyc >= expTicks * TICK_DIV - (TICK_DIV - 1) && cyc <= expTicks * TICK_DIV) else begin
         failCnt++;
         $error("FAIL %s:duration observed %0d cycles expected %0d..%0d", tag, cyc,
                expTicks * TICK_DIV - (TICK_DIV - 1), expTicks * TICK_DIV);
      end
      check({tag, ":ack_status"}, ackFlag, expAck);
      repeat (2) @(posedge clk);
      #1;
      obsVec = '0;
      for (int i = 0; i < obsBits.size() && i < 27; i++) obsVec = {obsVec[25:0], obsBits[i]};
      check({tag, ":bit_count"}, obsBits.size(), expLen);
      check({tag, ":bits"}, obsVec, expVec);
      check({tag, ":starts"}, startCnt - startBase, 1);
      check({tag, ":stops"}, stopCnt - stopBase, 1);
      if (holdCycles > 0) begin
         holdDrop = 0;
         for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            if (!endFlag || !busy) holdDrop++;
         end
         check({tag, ":end_held"}, holdDrop, 0);
         check({tag, ":no_retrigger"}, startCnt - startBase, 1);
      end
      @(negedge clk);
      go = 1'b0;
      @(posedge clk);
      #1;
      check({tag, ":end_cleared"}, endFlag, 1'b0);
      check({tag, ":busy_cleared"}, busy, 1'b0);
      check({tag, ":ack_retained"}, ackFlag, expAck);
      check({tag, ":scl_idle"}, scl, 1'b1);
      check({tag, ":sda_idle"}, sdaLine, 1'b1);
      $display("txn %s word=%06h nack=%03b bits=%0d ticks=%0d cycles=%0d oACK=%0b",
               tag, word, nack, obsBits.size(), expTicks, cyc, ackFlag);
   endtask

   initial begin
      int cyc, startBase;
      rstN = 1'b0;
      go   = 1'b0;
      data = 24'd0;
      #12;
      check("reset:oEND", endFlag, 1'b0);
      check("reset:oACK", ackFlag, 1'b0);
      check("reset:oBUSY", busy, 1'b0);
      check("reset:scl", scl, 1'b1);
      check("reset:sda", sdaLine, 1'b1);
      @(posedge clk);
      #1;
      rstN = 1'b1;

      runTxn("ref_all_ack", 24'h340E05, 3'b000, 0, 1'b0);
      runTxn("nack_byte2", 24'h401500, 3'b010, 0, 1'b0);

      // Asynchronous reset in the middle of the second byte.
      @(negedge clk);
      nackMask  = 3'b000;
      data      = 24'($urandom);
      go        = 1'b1;
      startBase = startCnt;
      cyc       = 0;
      while (!(startCnt > startBase && obsBits.size() >= 10) && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("rst_mid:reached_bit10", (startCnt > startBase && obsBits.size() >= 10), 1'b1);
      #2;
      rstN = 1'b0;
      #1;
      check("rst_mid:scl", scl, 1'b1);
      check("rst_mid:sda", sdaLine, 1'b1);
      check("rst_mid:oEND", endFlag, 1'b0);
      check("rst_mid:oBUSY", busy, 1'b0);
      check("rst_mid:oACK", ackFlag, 1'b0);
      $display("txn rst_mid reset asserted after %0d bits", obsBits.size());
      repeat (3) @(posedge clk);
      #1;
      rstN = 1'b1;
      runTxn("rst_restart", 24'($urandom), 3'b000, 0, 1'b0);

      runTxn("hold_go", 24'($urandom), 3'b000, 1000, 1'b0);
      runTxn("disturb", 24'($urandom), 3'b000, 0, 1'b1);

      for (int k = 0; k < 3; k++)
         runTxn($sformatf("b2b%0d", k), 24'($urandom), 3'b000, 0, 1'b0);
      for (int k = 0; k < 6; k++)
         runTxn($sformatf("rand%0d", k), 24'($urandom), 3'($urandom_range(0, 7)), 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
